// File: rtl/mips_mc_ctrl_if.sv
// Control/datapath bundle for the multicycle MIPS main controller.
// master = controller (mips_mc_ctrl), slave = datapath / instruction register side.
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, imm_zext, pc_src, pc_en, iord,
           mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, imm_zext, pc_src, pc_en, iord,
           mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal, state
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM (Moore outputs, async active-low reset).
// Define CTRL_MEMWAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module mips_mc_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  mips_mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  // Returns {known, alu_op}; known=0 marks an undecodable R-type funct.
  function automatic logic [4:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: funct_alu = {1'b1, ALU_ADD};
      6'b100010: funct_alu = {1'b1, ALU_SUB};
      6'b100100: funct_alu = {1'b1, ALU_AND};
      6'b100101: funct_alu = {1'b1, ALU_OR};
      6'b100110: funct_alu = {1'b1, ALU_XOR};
      6'b100111: funct_alu = {1'b1, ALU_NOR};
      6'b101010: funct_alu = {1'b1, ALU_SLT};
      default:   funct_alu = {1'b0, ALU_ADD};
    endcase
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      OP_XORI: imm_alu = ALU_XOR;
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_alu = ALU_ADD;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic       mem_rdy;
  logic [4:0] rt_dec;

  logic [3:0] alu_op_c;
  logic       src_a_c;
  logic [1:0] src_b_c;
  logic [1:0] pc_src_c;
  logic       pc_en_c, iord_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, illegal_c;

`ifdef CTRL_MEMWAIT_EN
  assign mem_rdy = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_rdy          = 1'b1;
`endif

  assign rt_dec = funct_alu(bus.funct);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    alu_op_c     = ALU_ADD;
    src_a_c      = 1'b0;
    src_b_c      = 2'b00;
    pc_src_c     = 2'b00;
    pc_en_c      = 1'b0;
    iord_c       = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        src_b_c    = 2'b01;
        ir_write_c = mem_rdy;
        pc_en_c    = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_b_c = 2'b11;
        case (bus.opcode)
          OP_RTYPE:                                state_d = S_RTEXEC;
          OP_LW, OP_SW:                            state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                          state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
          OP_SLTI:                                 state_d = S_IMMEXEC;
          OP_J:                                    state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        src_a_c = 1'b1;
        src_b_c = 2'b10;
        if (bus.opcode == OP_LW)      state_d = S_MEMRD;
        else if (bus.opcode == OP_SW) state_d = S_MEMWR;
        else                          state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord_c = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_RTEXEC: begin
        src_a_c  = 1'b1;
        alu_op_c = rt_dec[3:0];
        if (rt_dec[4]) begin
          state_d = S_RTWB;
        end else begin
          state_d   = S_FETCH;
          illegal_c = 1'b1;
        end
      end
      S_RTWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        // Branch target was latched into ALUOut during DECODE; the ALU now compares.
        src_a_c  = 1'b1;
        alu_op_c = ALU_SUB;
        pc_src_c = 2'b01;
        pc_en_c  = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
        state_d  = S_FETCH;
      end
      S_IMMEXEC: begin
        src_a_c  = 1'b1;
        src_b_c  = 2'b10;
        alu_op_c = imm_alu(bus.opcode);
        state_d  = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src_c = 2'b10;
        pc_en_c  = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.imm_zext   = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI) ||
                          (bus.opcode == OP_XORI);
  assign bus.alu_op     = alu_op_c;
  assign bus.alu_src_a  = src_a_c;
  assign bus.alu_src_b  = src_b_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.iord       = iord_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.state      = state_q;

  // Strobes are masked by rst_n so nothing fires while reset is held.
  assign bus.pc_en      = pc_en_c     & rst_n;
  assign bus.ir_write   = ir_write_c  & rst_n;
  assign bus.mem_write  = mem_write_c & rst_n;
  assign bus.reg_write  = reg_write_c & rst_n;
  assign bus.illegal    = illegal_c   & rst_n;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-instruction cycle traces from a reference
// model are queued by the driver and compared by a negedge monitor.
module tb_mips_mc_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mips_mc_ctrl_if bus();

  mips_mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic       zx;
    logic [1:0] ps;
    logic       pe;
    logic       io;
    logic       mw;
    logic       iw;
    logic       rd;
    logic       m2r;
    logic       rw;
    logic       ill;
  } out_t;

  typedef struct packed {
    out_t e;
    logic mr;
  } step_t;

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_IMM = 4, C_J = 5, C_ILL = 6;

  out_t  exp_q[$];
  step_t plan[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08,
                           6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h02};
  logic [5:0] fns [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};

  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'h00:                             return C_R;
      6'h23:                             return C_LW;
      6'h2b:                             return C_SW;
      6'h04, 6'h05:                      return C_BR;
      6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a: return C_IMM;
      6'h02:                             return C_J;
      default:                           return C_ILL;
    endcase
  endfunction

  // Returns {known, alu code} for an R-type funct.
  function automatic logic [4:0] ref_funct(input logic [5:0] fn);
    case (fn)
      6'h20:   return 5'h10;
      6'h22:   return 5'h12;
      6'h24:   return 5'h14;
      6'h25:   return 5'h15;
      6'h26:   return 5'h16;
      6'h27:   return 5'h17;
      6'h2a:   return 5'h1a;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [3:0] ref_imm(input logic [5:0] op);
    case (op)
      6'h0c:   return 4'h4;
      6'h0d:   return 4'h5;
      6'h0e:   return 4'h6;
      6'h0a:   return 4'ha;
      default: return 4'h0;
    endcase
  endfunction

  function automatic out_t blank(input logic [3:0] st, input logic [5:0] op);
    out_t r;
    r    = '0;
    r.st = st;
    r.zx = (op == 6'h0c) || (op == 6'h0d) || (op == 6'h0e);
    return r;
  endfunction

  function automatic out_t sample();
    out_t g;
    g.st  = bus.state;
    g.aop = bus.alu_op;
    g.sa  = bus.alu_src_a;
    g.sb  = bus.alu_src_b;
    g.zx  = bus.imm_zext;
    g.ps  = bus.pc_src;
    g.pe  = bus.pc_en;
    g.io  = bus.iord;
    g.mw  = bus.mem_write;
    g.iw  = bus.ir_write;
    g.rd  = bus.reg_dst;
    g.m2r = bus.mem_to_reg;
    g.rw  = bus.reg_write;
    g.ill = bus.illegal;
    return g;
  endfunction

  task automatic add_step(input out_t e, input logic mr);
    step_t s;
    s.e  = e;
    s.mr = mr;
    plan.push_back(s);
  endtask

  task automatic add_rnd(input out_t e);
    add_step(e, 1'($urandom_range(0, 1)));
  endtask

  // Memory-handshaked stage: w cycles with mem_ready low, then the completing cycle.
  task automatic add_mem_stage(input out_t busy, input out_t done, input int w);
`ifdef CTRL_MEMWAIT_EN
    for (int i = 0; i < w; i++) add_step(busy, 1'b0);
    add_step(done, 1'b1);
`else
    add_step(done, (w > 0) ? 1'b0 : 1'b1);
`endif
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm);
    out_t a, b;
    logic [4:0] rf;
    plan.delete();
    a    = blank(4'd0, op);
    a.sb = 2'b01;
    b    = a;
    b.iw = 1'b1;
    b.pe = 1'b1;
    add_mem_stage(a, b, wf);
    a    = blank(4'd1, op);
    a.sb = 2'b11;
    if (cls_of(op) == C_ILL) a.ill = 1'b1;
    add_rnd(a);
    case (cls_of(op))
      C_R: begin
        rf    = ref_funct(fn);
        a     = blank(4'd6, op);
        a.sa  = 1'b1;
        a.aop = rf[3:0];
        if (!rf[4]) begin
          a.ill = 1'b1;
          add_rnd(a);
        end else begin
          add_rnd(a);
          a    = blank(4'd7, op);
          a.rd = 1'b1;
          a.rw = 1'b1;
          add_rnd(a);
        end
      end
      C_LW, C_SW: begin
        a    = blank(4'd2, op);
        a.sa = 1'b1;
        a.sb = 2'b10;
        add_rnd(a);
        if (cls_of(op) == C_LW) begin
          a    = blank(4'd3, op);
          a.io = 1'b1;
          add_mem_stage(a, a, wm);
          a     = blank(4'd4, op);
          a.m2r = 1'b1;
          a.rw  = 1'b1;
          add_rnd(a);
        end else begin
          a    = blank(4'd5, op);
          a.io = 1'b1;
          a.mw = 1'b1;
          add_mem_stage(a, a, wm);
        end
      end
      C_BR: begin
        a     = blank(4'd8, op);
        a.sa  = 1'b1;
        a.aop = 4'b0010;
        a.ps  = 2'b01;
        a.pe  = (op == 6'h04) ? z : ~z;
        add_rnd(a);
      end
      C_IMM: begin
        a     = blank(4'd9, op);
        a.sa  = 1'b1;
        a.sb  = 2'b10;
        a.aop = ref_imm(op);
        add_rnd(a);
        a    = blank(4'd10, op);
        a.rw = 1'b1;
        add_rnd(a);
      end
      C_J: begin
        a    = blank(4'd11, op);
        a.ps = 2'b10;
        a.pe = 1'b1;
        add_rnd(a);
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1; each step occupies one full clock period.
  task automatic run_plan(input int maxc);
    for (int i = 0; i < plan.size() && i < maxc; i++) begin
      bus.mem_ready = plan[i].mr;
      exp_q.push_back(plan[i].e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int wf, input int wm, input int maxc);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    build(op, fn, z, wf, wm);
    run_plan(maxc);
  endtask

  task automatic do_reset(input int n);
    out_t r;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      r             = blank(4'd0, bus.opcode);
      r.sb          = 2'b01;
      bus.mem_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(r);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    out_t got, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = sample();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL vec%0d t=%0t state got=%0d want=%0d outputs got=%h want=%h",
                 vectors, $time, got.st, want.st, got, want);
      end
    end
  end

  initial begin
    int k;
    logic [5:0] op, fn;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    do_instr(6'h00, 6'h20, 1'b0, 0, 0, 99);   // add
    do_instr(6'h23, 6'h00, 1'b0, 0, 2, 99);   // lw with two wait cycles in MEMRD
    do_instr(6'h2b, 6'h00, 1'b0, 1, 1, 99);   // sw
    do_instr(6'h04, 6'h00, 1'b1, 0, 0, 99);   // beq taken
    do_instr(6'h04, 6'h00, 1'b0, 0, 0, 99);   // beq not taken
    do_instr(6'h05, 6'h00, 1'b0, 0, 0, 99);   // bne taken
    do_instr(6'h05, 6'h00, 1'b1, 0, 0, 99);   // bne not taken
    do_instr(6'h0d, 6'h00, 1'b0, 0, 0, 99);   // ori
    do_instr(6'h3f, 6'h00, 1'b0, 0, 0, 99);   // illegal opcode
    do_instr(6'h00, 6'h3f, 1'b0, 0, 0, 99);   // illegal funct
    do_instr(6'h02, 6'h00, 1'b0, 0, 0, 99);   // jump
    do_instr(6'h23, 6'h00, 1'b0, 0, 0, 3);    // lw aborted in MEMADR
    do_reset(2);

    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 11);
      op = (k == 11) ? 6'($urandom_range(0, 63)) : ops[k];
      k  = $urandom_range(0, 8);
      fn = (k > 6) ? 6'($urandom_range(0, 63)) : fns[k];
      if ($urandom_range(0, 19) == 0) begin
        do_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end else begin
        do_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 $urandom_range(0, 2), 99);
      end
    end

    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle MIPS main control FSM; the initiator side of the ALU interface.
- Sequences fetch/decode/execute/memory/writeback for every instruction.
- Drives the 4-bit ALU operation code, mux selects and write strobes; consumes the ALU ZERO flag for branches.
- Sits between the instruction register (opcode/funct) and the datapath; one instance per core.

Parameters:
- None. Encodings are fixed by the ALU operation codes and the MIPS ISA.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH
funct  in  6  IR[5:0]; same stability rule
zero  in  1  ALU ZERO flag, valid in BRANCH
mem_ready  in  1  memory access complete (honoured only with CTRL_MEMWAIT_EN)
alu_op  out  4  ALU op: 0000 add, 0010 sub, 0100 and, 0101 or, 0110 xor, 0111 nor, 1010 slt
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 4, 10=ext imm, 11=ext imm<<2
imm_zext  out  1  1=zero-extend imm (andi/ori/xori), 0=sign-extend; combinational from opcode
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
pc_en  out  1  PC write enable
iord  out  1  memory address 0=PC, 1=ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
reg_write  out  1  register file write
illegal  out  1  one-cycle pulse on undecodable instruction
state  out  4  current state, debug

Behaviour:
- Reset (rst_n low, async): state=FETCH(0). pc_en, ir_write, mem_write, reg_write and illegal forced 0 while rst_n low. Other outputs take FETCH values.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, BRANCH 8, IMMEXEC 9, IMMWB 10, JUMP 11. Codes 12-15 go to FETCH on the next clock.
- Moore outputs; any output not listed for a state is 0, and alu_op defaults to 0000.
- FETCH: src_b=01, ir_write=1, pc_en=1 -> DECODE.
- DECODE: src_b=11 (branch target). Next state by opcode:
  - 000000 -> RTEXEC
  - 100011/101011 -> MEMADR
  - 000100/000101 -> BRANCH
  - 001000/001100/001101/001110/001010 -> IMMEXEC
  - 000010 -> JUMP
  - other -> FETCH with illegal=1 for that cycle.
- MEMADR: src_a=1, src_b=10. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWR: iord=1, mem_write=1 -> FETCH.
- RTEXEC: src_a=1, src_b=00. alu_op from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt.
  - Unknown funct: -> FETCH with illegal=1, no writeback.
  - Otherwise -> RTWB.
- RTWB: reg_dst=1, reg_write=1 -> FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=0010, pc_src=01. pc_en=zero for beq, ~zero for bne (combinational on zero) -> FETCH.
- IMMEXEC: src_a=1, src_b=10. alu_op from opcode: addi add, andi and, ori or, xori xor, slti slt -> IMMWB.
- IMMWB: reg_write=1 -> FETCH.
- JUMP: pc_src=10, pc_en=1 -> FETCH.
- Cycle counts (no stalls): R/imm 4, lw 5, sw 4, branch 3, jump 3.
- Reset mid-instruction: abort immediately; no strobe is asserted after rst_n falls.

Optional Feature:
- Macro CTRL_MEMWAIT_EN.
- With it:
  - FETCH holds until mem_ready=1; ir_write and pc_en are asserted only in the mem_ready=1 cycle.
  - MEMRD holds until mem_ready=1.
  - MEMWR holds mem_write=1 until mem_ready=1, then leaves.
- Without it: mem_ready is ignored and treated as constant 1; timing is as above.

Test Plan:
- Reset: rst_n=0 for 3 clocks -> state=0, pc_en=ir_write=mem_write=reg_write=0. Release -> ir_write=1, pc_en=1 on the first cycle.
- add (opcode 0, funct 100000): states 0,1,6,7,0. alu_op=0000 in state 6; reg_dst=1 and reg_write=1 in state 7.
- lw (100011): states 0,1,2,3,4. iord=1 in state 3; mem_to_reg=1 and reg_write=1 in state 4. sw (101011): mem_write=1 in state 5, then FETCH.
- beq with zero=1 -> pc_en=1, pc_src=01, alu_op=0010. beq with zero=0 -> pc_en=0. bne with zero=0 -> pc_en=1.
- ori (001101): imm_zext=1, alu_op=0101 in state 9, reg_write=1 in state 10. Illegal opcode 111111 -> illegal pulses 1 cycle in state 1, next state 0, no write strobes.
- CTRL_MEMWAIT_EN: lw with mem_ready=0 for 2 cycles in MEMRD -> state stays 3 for 3 cycles total, then 4. Without the macro, same stimulus -> 3 for 1 cycle.
